// File: rtl/p4_normalizer.sv
// Multi-cycle left-normalizer: shifts an operand left one bit per clock until it is
// left-justified (unsigned) or sign-justified (signed), reporting the shift count.
module p4_normalizer #(
  parameter int WIDTH = 16,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [CW-1:0]    count,
  output logic             zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start/mode/in are sampled only in IDLE; busy is high from the cycle
  // after acceptance through the DONE cycle; done is a one-cycle pulse with out/count/zero valid.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] wv_q, wv_d;
  logic [CW-1:0]    wc_q, wc_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    count_q, count_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] wv_shl;
  logic [CW-1:0]    wc_inc;
  logic             in_norm;
  logic             shl_norm;

  function automatic logic is_norm(input logic [WIDTH-1:0] v, input logic m);
    is_norm = m ? (v[WIDTH-1] != v[WIDTH-2]) : v[WIDTH-1];
  endfunction

  assign wv_shl   = {wv_q[WIDTH-2:0], 1'b0};
  assign wc_inc   = wc_q + 1'b1;
  assign in_norm  = is_norm(in, mode);
  assign shl_norm = is_norm(wv_shl, mode_q);

  always_comb begin
    state_d = state_q;
    wv_d    = wv_q;
    wc_d    = wc_q;
    mode_d  = mode_q;
    out_d   = out_q;
    count_d = count_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          wv_d   = in;
          wc_d   = '0;
          mode_d = mode;
          if ((in == '0) || in_norm) begin
            // Already justified (or zero): the result is published on the accepting edge.
            state_d = S_DONE;
            out_d   = in;
            count_d = '0;
            zero_d  = (in == '0);
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        wv_d = wv_shl;
        wc_d = wc_inc;
        if (shl_norm || (wc_inc == CW'(WIDTH-1))) begin
          state_d = S_DONE;
          out_d   = wv_shl;
          count_d = wc_inc;
          zero_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wv_q    <= '0;
      wc_q    <= '0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wv_q    <= wv_d;
      wc_q    <= wc_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out       = out_q;
  assign count     = count_q;
  assign zero      = zero_q;
  assign state_dbg = 2'(state_q);

endmodule

// File: tb/tb_p4_normalizer.sv
// Directed bench for p4_normalizer: hand-computed results, latency and handshake checks.
module tb_p4_normalizer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [15:0] in_v;
  logic        busy;
  logic        done;
  logic [15:0] out_v;
  logic [3:0]  count;
  logic        zero;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  p4_normalizer #(.WIDTH(16), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .in        (in_v),
    .busy      (busy),
    .done      (done),
    .out       (out_v),
    .count     (count),
    .zero      (zero),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; everything is driven and sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to the DONE cycle and the IDLE cycle after it.
  // inject_at: cycle (since start) at which a stray start with in=1234 is pulsed (0 = none).
  // poke_done: also pulse a stray start during the DONE cycle.
  task automatic run_op(input string name, input logic [15:0] v, input logic m,
                        input logic [15:0] eo, input int ec, input logic ez,
                        input int inject_at, input bit poke_done);
    int lat;
    start = 1'b1;
    in_v  = v;
    mode  = m;
    step();
    start = 1'b0;
    in_v  = 16'($urandom_range(0, 65535));
    mode  = 1'($urandom_range(0, 1));
    lat   = 1;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) chk({name, "_busy_mid"}, 32'(busy), 32'd1);
      if (lat == inject_at) begin
        start = 1'b1;
        in_v  = 16'h1234;
        mode  = 1'b1;
      end
      step();
      start = 1'b0;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(ec + 1));
    chk({name, "_done"},    32'(done),  32'd1);
    chk({name, "_busy"},    32'(busy),  32'd1);
    chk({name, "_out"},     32'(out_v), 32'(eo));
    chk({name, "_count"},   32'(count), 32'(ec));
    chk({name, "_zero"},    32'(zero),  32'(ez));
    if (poke_done) begin
      start = 1'b1;
      in_v  = 16'h1234;
      mode  = 1'b0;
    end
    step();
    start = 1'b0;
    chk({name, "_done_pulse"}, 32'(done),  32'd0);
    chk({name, "_idle_busy"},  32'(busy),  32'd0);
    chk({name, "_hold_out"},   32'(out_v), 32'(eo));
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    in_v  = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_out",   32'(out_v), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_zero",  32'(zero),  32'd0);
    step();

    run_op("u0001", 16'h0001, 1'b0, 16'h8000, 15, 1'b0, 0, 1'b0);
    run_op("s0001", 16'h0001, 1'b1, 16'h4000, 14, 1'b0, 0, 1'b0);
    run_op("u8000", 16'h8000, 1'b0, 16'h8000, 0,  1'b0, 0, 1'b0);
    run_op("sC000", 16'hC000, 1'b1, 16'h8000, 1,  1'b0, 0, 1'b0);
    run_op("s8000", 16'h8000, 1'b1, 16'h8000, 0,  1'b0, 0, 1'b0);
    run_op("s0300", 16'h0300, 1'b1, 16'h6000, 5,  1'b0, 0, 1'b0);
    run_op("u0000", 16'h0000, 1'b0, 16'h0000, 0,  1'b1, 0, 1'b0);
    run_op("s0000", 16'h0000, 1'b1, 16'h0000, 0,  1'b1, 0, 1'b0);
    run_op("sFFFF", 16'hFFFF, 1'b1, 16'h8000, 15, 1'b0, 0, 1'b1);
    // stray start mid-operation, then back-to-back start in the first IDLE cycle
    run_op("ign",   16'h0001, 1'b0, 16'h8000, 15, 1'b0, 3, 1'b0);
    run_op("b2b",   16'h00F0, 1'b0, 16'hF000, 8,  1'b0, 0, 1'b1);
    step();

    // reset during an operation aborts it and clears the registered results
    start = 1'b1;
    in_v  = 16'h0001;
    mode  = 1'b0;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    chk("mid_rst_busy",  32'(busy),  32'd0);
    chk("mid_rst_done",  32'(done),  32'd0);
    chk("mid_rst_out",   32'(out_v), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_zero",  32'(zero),  32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    chk("mid_rst_no_done", 32'(saw_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
